// File: rtl/if_fetch_stage_pkg.sv
// Shared defines for the IF stage: bus widths, stall-vector bit positions,
// chip-enable levels and the PC-source selector used by the PC generator.
package if_fetch_stage_pkg;

   localparam int          InstAddrBus = 32;
   localparam int          InstBus     = 32;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;

   // Bit positions inside the 6-bit ctrl stall vector.
   localparam int StallPc = 0;
   localparam int StallIf = 1;
   localparam int StallId = 2;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   typedef logic [InstAddrBus-1:0] inst_addr_t;
   typedef logic [InstBus-1:0]     inst_t;

   // Which source the PC register takes on the coming edge, in priority order.
   typedef enum logic [2:0] {
      PC_SEL_RESET  = 3'd0,
      PC_SEL_FLUSH  = 3'd1,
      PC_SEL_STALL  = 3'd2,
      PC_SEL_BRANCH = 3'd3,
      PC_SEL_SEQ    = 3'd4
   } pc_sel_e;

   // A redirect is any edge where the PC leaves the sequential stream.
   function automatic logic is_redirect(input pc_sel_e sel);
      return (sel == PC_SEL_FLUSH) || (sel == PC_SEL_BRANCH);
   endfunction

endpackage

// File: rtl/if_fetch_stage_pc_gen.sv
// PC register and ROM chip enable. The PC is held at RESET_PC while ce is
// low, so the first fetch after reset is from RESET_PC. pc_sel exposes the
// selected PC source for debug/checker binding.
module if_fetch_stage_pc_gen
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       stall_pc,
   input  logic       flush,
   input  inst_addr_t new_pc,
   input  logic       branch_flag,
   input  inst_addr_t branch_target,
   output inst_addr_t pc,
   output logic       ce,
   output pc_sel_e    pc_sel,
   output logic       redirect
);

   inst_addr_t pc_next;

   // Chip enable rises on the first edge out of reset and then stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ce <= ChipDisable;
      else     ce <= ChipEnable;
   end

   // Next-PC selection: disabled > flush > stall > branch > sequential.
   // A branch seen under a PC stall is simply not taken; ID keeps presenting
   // it, so it is taken on the first unstalled edge.
   always_comb begin
      pc_sel  = PC_SEL_SEQ;
      pc_next = pc + PC_STEP;
      if (ce == ChipDisable) begin
         pc_sel  = PC_SEL_RESET;
         pc_next = RESET_PC;
      end else if (flush) begin
         pc_sel  = PC_SEL_FLUSH;
         pc_next = new_pc;
      end else if (stall_pc) begin
         pc_sel  = PC_SEL_STALL;
         pc_next = pc;
      end else if (branch_flag) begin
         pc_sel  = PC_SEL_BRANCH;
         pc_next = branch_target;
      end
   end

   // PC register update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= RESET_PC;
      else     pc <= pc_next;
   end

   assign redirect = is_redirect(pc_sel);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: PC generation, IF/ID pipeline register and
// fetch/redirect counters. The instruction fetched when a branch resolves is
// the delay slot and is passed to ID untouched.
// Optional macro IF_FETCH_ALIGN_CHECK_EN: flags misaligned fetch addresses on
// id_excp_adel and replaces the instruction with zero.
// Stall/flush semantics: stall[1] with stall[2] low inserts a bubble into
// IF/ID; stall[1] with stall[2] high holds IF/ID; flush overrides both.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   input  logic [31:0] inst_i,
   output logic [31:0] pc,
   output logic        ce,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [31:0] fetch_cnt,
   output logic [31:0] redirect_cnt,
   output logic        id_excp_adel
);

   pc_sel_e pc_sel;
   logic    redirect;
   logic    if_bubble;
   logic    if_load;
   logic    fetch_real;
   inst_t   load_inst;
   logic    load_adel;
   logic    unused_stall;

   // Upper stall bits belong to later stages and are not used here.
   assign unused_stall = ^{stall[5:3], pc_sel};

   if_fetch_stage_pc_gen #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_gen (
      .clk           (clk),
      .rst           (rst),
      .stall_pc      (stall[StallPc]),
      .flush         (flush),
      .new_pc        (new_pc),
      .branch_flag   (branch_flag_i),
      .branch_target (branch_target_address_i),
      .pc            (pc),
      .ce            (ce),
      .pc_sel        (pc_sel),
      .redirect      (redirect)
   );

   assign if_bubble  = flush || (stall[StallIf] && !stall[StallId]);
   assign if_load    = !flush && !stall[StallIf];
   assign fetch_real = if_load && (ce == ChipEnable);

`ifdef IF_FETCH_ALIGN_CHECK_EN
   // A fetch from a non-word address delivers a zero word plus an ADEL flag.
   always_comb begin
      load_adel = (pc[1:0] != 2'b00);
      load_inst = load_adel ? ZeroWord : inst_i;
   end
`else
   // Without the alignment check the ROM word passes straight through.
   always_comb begin
      load_adel = 1'b0;
      load_inst = inst_i;
   end
`endif

   // IF/ID pipeline register: bubble, load or hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc   <= ZeroWord;
         id_inst <= ZeroWord;
      end else if (if_bubble) begin
         id_pc   <= ZeroWord;
         id_inst <= ZeroWord;
      end else if (if_load) begin
         if (ce == ChipEnable) begin
            id_pc   <= pc;
            id_inst <= load_inst;
         end else begin
            id_pc   <= ZeroWord;
            id_inst <= ZeroWord;
         end
      end
   end

`ifdef IF_FETCH_ALIGN_CHECK_EN
   // ADEL flag travels with the IF/ID contents; bubbles clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             id_excp_adel <= 1'b0;
      else if (if_bubble)  id_excp_adel <= 1'b0;
      else if (fetch_real) id_excp_adel <= load_adel;
      else if (if_load)    id_excp_adel <= 1'b0;
   end
`else
   assign id_excp_adel = 1'b0;
   logic unused_adel;
   assign unused_adel = load_adel;
`endif

   // Fetch counter: real instructions accepted into IF/ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             fetch_cnt <= '0;
      else if (fetch_real) fetch_cnt <= fetch_cnt + 32'd1;
   end

   // Redirect counter: edges where the PC took a flush or branch target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           redirect_cnt <= '0;
      else if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
   end

endmodule
